// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection and EX operand forwarding.
// Control bits are cleared on flush/bubble; data fields are left as-is since they are don't-care when invalid.
module id_ex_stage #(
   parameter int DATA_WIDTH     = 32,
   parameter int SEL_WIDTH      = 4,
   parameter int REG_ADDR_WIDTH = 5
) (
   input  logic                      i_clk,
   input  logic                      i_rst,
   input  logic                      i_id_valid,
   input  logic [REG_ADDR_WIDTH-1:0] i_id_rs1_addr,
   input  logic [REG_ADDR_WIDTH-1:0] i_id_rs2_addr,
   input  logic [REG_ADDR_WIDTH-1:0] i_id_rd_addr,
   input  logic                      i_id_rs1_used,
   input  logic                      i_id_rs2_used,
   input  logic [DATA_WIDTH-1:0]     i_id_rs1_data,
   input  logic [DATA_WIDTH-1:0]     i_id_rs2_data,
   input  logic [DATA_WIDTH-1:0]     i_id_imm,
   input  logic [SEL_WIDTH-1:0]      i_id_alu_sel,
   input  logic                      i_id_use_imm,
   input  logic                      i_id_reg_write,
   input  logic                      i_id_mem_read,
   input  logic                      i_flush,
   input  logic                      i_ex_hold,
   input  logic                      i_mem_reg_write,
   input  logic [REG_ADDR_WIDTH-1:0] i_mem_rd_addr,
   input  logic [DATA_WIDTH-1:0]     i_mem_data,
   input  logic                      i_wb_reg_write,
   input  logic [REG_ADDR_WIDTH-1:0] i_wb_rd_addr,
   input  logic [DATA_WIDTH-1:0]     i_wb_data,
   output logic                      o_stall,
   output logic                      o_ex_valid,
   output logic [DATA_WIDTH-1:0]     o_src_a,
   output logic [DATA_WIDTH-1:0]     o_src_b,
   output logic [SEL_WIDTH-1:0]      o_alu_sel,
   output logic [DATA_WIDTH-1:0]     o_store_data,
   output logic [REG_ADDR_WIDTH-1:0] o_ex_rd_addr,
   output logic                      o_ex_reg_write,
   output logic                      o_ex_mem_read
);

   logic                      ex_valid;
   logic                      ex_reg_write;
   logic                      ex_mem_read;
   logic                      ex_use_imm;
   logic [REG_ADDR_WIDTH-1:0] ex_rs1_addr;
   logic [REG_ADDR_WIDTH-1:0] ex_rs2_addr;
   logic [REG_ADDR_WIDTH-1:0] ex_rd_addr;
   logic [DATA_WIDTH-1:0]     ex_rs1_data;
   logic [DATA_WIDTH-1:0]     ex_rs2_data;
   logic [DATA_WIDTH-1:0]     ex_imm;
   logic [SEL_WIDTH-1:0]      ex_alu_sel;

   logic                      load_use;
   logic [DATA_WIDTH-1:0]     rs1_fwd;
   logic [DATA_WIDTH-1:0]     rs2_fwd;

   always_comb begin
      load_use = ex_valid && ex_mem_read && (ex_rd_addr != '0) && i_id_valid &&
                 ((i_id_rs1_used && (i_id_rs1_addr == ex_rd_addr)) ||
                  (i_id_rs2_used && (i_id_rs2_addr == ex_rd_addr)));
      o_stall  = !i_flush && (i_ex_hold || load_use);
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         ex_valid     <= 1'b0;
         ex_reg_write <= 1'b0;
         ex_mem_read  <= 1'b0;
         ex_use_imm   <= 1'b0;
         ex_rs1_addr  <= '0;
         ex_rs2_addr  <= '0;
         ex_rd_addr   <= '0;
         ex_rs1_data  <= '0;
         ex_rs2_data  <= '0;
         ex_imm       <= '0;
         ex_alu_sel   <= '0;
      end else if (i_flush || (!i_ex_hold && load_use)) begin
         ex_valid     <= 1'b0;
         ex_reg_write <= 1'b0;
         ex_mem_read  <= 1'b0;
      end else if (!i_ex_hold) begin
         // Gating with valid keeps reg_write/mem_read low for empty slots.
         ex_valid     <= i_id_valid;
         ex_reg_write <= i_id_valid && i_id_reg_write;
         ex_mem_read  <= i_id_valid && i_id_mem_read;
         ex_use_imm   <= i_id_use_imm;
         ex_rs1_addr  <= i_id_rs1_addr;
         ex_rs2_addr  <= i_id_rs2_addr;
         ex_rd_addr   <= i_id_rd_addr;
         ex_rs1_data  <= i_id_rs1_data;
         ex_rs2_data  <= i_id_rs2_data;
         ex_imm       <= i_id_imm;
         ex_alu_sel   <= i_id_alu_sel;
      end
   end

   // MEM result is younger than WB, so it wins when both match.
   always_comb begin
      rs1_fwd = ex_rs1_data;
      if (i_mem_reg_write && (i_mem_rd_addr != '0) && (i_mem_rd_addr == ex_rs1_addr))
         rs1_fwd = i_mem_data;
      else if (i_wb_reg_write && (i_wb_rd_addr != '0) && (i_wb_rd_addr == ex_rs1_addr))
         rs1_fwd = i_wb_data;

      rs2_fwd = ex_rs2_data;
      if (i_mem_reg_write && (i_mem_rd_addr != '0) && (i_mem_rd_addr == ex_rs2_addr))
         rs2_fwd = i_mem_data;
      else if (i_wb_reg_write && (i_wb_rd_addr != '0) && (i_wb_rd_addr == ex_rs2_addr))
         rs2_fwd = i_wb_data;
   end

   always_comb begin
      o_ex_valid     = ex_valid;
      o_ex_reg_write = ex_reg_write;
      o_ex_mem_read  = ex_mem_read;
      o_ex_rd_addr   = ex_rd_addr;
      o_alu_sel      = ex_alu_sel;
      o_src_a        = rs1_fwd;
      o_src_b        = ex_use_imm ? ex_imm : rs2_fwd;
      o_store_data   = rs2_fwd;
   end

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: directed scenarios with literal expectations, then random traffic
// checked every cycle against a behavioural model of the EX slot.
module tb_id_ex_stage;

   logic        clk = 1'b0;
   logic        rst;
   logic        id_valid, id_rs1_used, id_rs2_used, id_use_imm, id_reg_write, id_mem_read;
   logic [4:0]  id_rs1_addr, id_rs2_addr, id_rd_addr;
   logic [31:0] id_rs1_data, id_rs2_data, id_imm;
   logic [3:0]  id_alu_sel;
   logic        flush, ex_hold;
   logic        mem_reg_write, wb_reg_write;
   logic [4:0]  mem_rd_addr, wb_rd_addr;
   logic [31:0] mem_data, wb_data;
   logic        stall, ex_valid, ex_reg_write, ex_mem_read;
   logic [31:0] src_a, src_b, store_data;
   logic [3:0]  alu_sel;
   logic [4:0]  ex_rd_addr;

   int vectors = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   id_ex_stage #(.DATA_WIDTH(32), .SEL_WIDTH(4), .REG_ADDR_WIDTH(5)) dut (
      .i_clk(clk), .i_rst(rst), .i_id_valid(id_valid),
      .i_id_rs1_addr(id_rs1_addr), .i_id_rs2_addr(id_rs2_addr), .i_id_rd_addr(id_rd_addr),
      .i_id_rs1_used(id_rs1_used), .i_id_rs2_used(id_rs2_used),
      .i_id_rs1_data(id_rs1_data), .i_id_rs2_data(id_rs2_data), .i_id_imm(id_imm),
      .i_id_alu_sel(id_alu_sel), .i_id_use_imm(id_use_imm), .i_id_reg_write(id_reg_write),
      .i_id_mem_read(id_mem_read), .i_flush(flush), .i_ex_hold(ex_hold),
      .i_mem_reg_write(mem_reg_write), .i_mem_rd_addr(mem_rd_addr), .i_mem_data(mem_data),
      .i_wb_reg_write(wb_reg_write), .i_wb_rd_addr(wb_rd_addr), .i_wb_data(wb_data),
      .o_stall(stall), .o_ex_valid(ex_valid), .o_src_a(src_a), .o_src_b(src_b),
      .o_alu_sel(alu_sel), .o_store_data(store_data), .o_ex_rd_addr(ex_rd_addr),
      .o_ex_reg_write(ex_reg_write), .o_ex_mem_read(ex_mem_read)
   );

   // Model of the instruction sitting in EX.
   typedef struct {
      bit          v, rw, mr, ui;
      int          rs1, rs2, rd, sel;
      logic [31:0] d1, d2, imm;
   } slot_t;
   slot_t m;

   function automatic void model_clear();
      m = '{v:0, rw:0, mr:0, ui:0, rs1:0, rs2:0, rd:0, sel:0, d1:0, d2:0, imm:0};
   endfunction

   function automatic bit model_load_use();
      return m.v && m.mr && m.rd != 0 && id_valid &&
             ((id_rs1_used && int'(id_rs1_addr) == m.rd) || (id_rs2_used && int'(id_rs2_addr) == m.rd));
   endfunction

   function automatic logic [31:0] model_operand(input int addr, input logic [31:0] regval);
      if (mem_reg_write && mem_rd_addr != 0 && int'(mem_rd_addr) == addr) return mem_data;
      if (wb_reg_write && wb_rd_addr != 0 && int'(wb_rd_addr) == addr) return wb_data;
      return regval;
   endfunction

   function automatic void model_edge();
      bit kill;
      kill = flush || (!ex_hold && model_load_use());
      if (kill) begin
         m.v = 0; m.rw = 0; m.mr = 0;
      end else if (!ex_hold) begin
         m.v = id_valid; m.rw = id_valid && id_reg_write; m.mr = id_valid && id_mem_read;
         m.ui = id_use_imm; m.rs1 = id_rs1_addr; m.rs2 = id_rs2_addr; m.rd = id_rd_addr;
         m.sel = id_alu_sel; m.d1 = id_rs1_data; m.d2 = id_rs2_data; m.imm = id_imm;
      end
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
      end
   endtask

   task automatic check_model();
      logic [31:0] a, b2;
      chk("stall", 32'(stall), 32'(!flush && (ex_hold || model_load_use())));
      chk("ex_valid", 32'(ex_valid), 32'(m.v));
      chk("ex_reg_write", 32'(ex_reg_write), 32'(m.rw));
      chk("ex_mem_read", 32'(ex_mem_read), 32'(m.mr));
      if (m.v) begin
         a  = model_operand(m.rs1, m.d1);
         b2 = model_operand(m.rs2, m.d2);
         chk("ex_rd_addr", 32'(ex_rd_addr), 32'(m.rd));
         chk("alu_sel", 32'(alu_sel), 32'(m.sel));
         chk("src_a", src_a, a);
         chk("src_b", src_b, m.ui ? m.imm : b2);
         chk("store_data", store_data, b2);
      end
   endtask

   // Compare at the falling edge, then advance model and DUT together on the rising edge.
   task automatic cycle();
      @(negedge clk);
      check_model();
      @(posedge clk);
      model_edge();
      #1;
   endtask

   task automatic async_reset_pulse();
      #1 rst = 1'b1;
      #1;
      model_clear();
      chk("async_rst_valid", 32'(ex_valid), 32'd0);
      chk("async_rst_reg_write", 32'(ex_reg_write), 32'd0);
      #1 rst = 1'b0;
   endtask

   task automatic set_id(input bit v, input int rs1, input logic [31:0] d1, input int rs2,
                         input logic [31:0] d2, input int rd, input bit rw, input bit mr);
      id_valid = v; id_rs1_addr = 5'(rs1); id_rs2_addr = 5'(rs2); id_rd_addr = 5'(rd);
      id_rs1_data = d1; id_rs2_data = d2; id_rs1_used = 1'b1; id_rs2_used = 1'b1;
      id_imm = 32'h1234; id_alu_sel = 4'd0; id_use_imm = 1'b0;
      id_reg_write = rw; id_mem_read = mr;
   endtask

   task automatic no_fwd();
      mem_reg_write = 0; mem_rd_addr = 0; mem_data = 0;
      wb_reg_write = 0; wb_rd_addr = 0; wb_data = 0;
   endtask

   task automatic randomize_inputs();
      id_valid = ($urandom_range(0, 7) != 0);
      id_rs1_addr = 5'($urandom_range(0, 3)); id_rs2_addr = 5'($urandom_range(0, 3));
      id_rd_addr = 5'($urandom_range(0, 3));
      id_rs1_used = 1'($urandom); id_rs2_used = 1'($urandom);
      id_rs1_data = $urandom; id_rs2_data = $urandom; id_imm = $urandom;
      id_alu_sel = 4'($urandom); id_use_imm = 1'($urandom);
      id_reg_write = 1'($urandom); id_mem_read = ($urandom_range(0, 2) == 0);
      flush = ($urandom_range(0, 9) == 0); ex_hold = ($urandom_range(0, 7) == 0);
      mem_reg_write = 1'($urandom); mem_rd_addr = 5'($urandom_range(0, 3)); mem_data = $urandom;
      wb_reg_write = 1'($urandom); wb_rd_addr = 5'($urandom_range(0, 3)); wb_data = $urandom;
   endtask

   initial begin
      rst = 1'b1; flush = 0; ex_hold = 0;
      set_id(0, 0, 0, 0, 0, 0, 0, 0);
      no_fwd();
      model_clear();
      @(posedge clk); #1;
      chk("reset_valid", 32'(ex_valid), 32'd0);
      chk("reset_reg_write", 32'(ex_reg_write), 32'd0);
      chk("reset_mem_read", 32'(ex_mem_read), 32'd0);
      chk("reset_alu_sel", 32'(alu_sel), 32'd0);
      chk("reset_rd_addr", 32'(ex_rd_addr), 32'd0);
      chk("reset_src_a", src_a, 32'd0);
      rst = 1'b0;

      // Basic load into EX.
      set_id(1, 3, 32'd5, 4, 32'd7, 6, 1, 0);
      cycle();
      chk("basic_src_a", src_a, 32'd5);
      chk("basic_src_b", src_b, 32'd7);
      chk("basic_alu_sel", 32'(alu_sel), 32'd0);
      chk("basic_valid", 32'(ex_valid), 32'd1);

      // Forwarding priority on rs1=3.
      mem_reg_write = 1; mem_rd_addr = 3; mem_data = 32'hAA;
      wb_reg_write = 1; wb_rd_addr = 3; wb_data = 32'hBB;
      #1 chk("fwd_mem", src_a, 32'hAA);
      mem_reg_write = 0;
      #1 chk("fwd_wb", src_a, 32'hBB);
      mem_reg_write = 1; mem_rd_addr = 0; wb_rd_addr = 0;
      #1 chk("fwd_x0", src_a, 32'd5);
      no_fwd();

      // Load-use: load rd=5 then consumer of x5 via rs2.
      set_id(1, 0, 0, 0, 0, 5, 1, 1);
      cycle();
      set_id(1, 1, 32'd11, 5, 32'd22, 7, 1, 0);
      id_rs1_used = 0;
      #1 chk("lu_stall", 32'(stall), 32'd1);
      cycle();
      chk("lu_bubble_valid", 32'(ex_valid), 32'd0);
      chk("lu_bubble_stall", 32'(stall), 32'd0);
      cycle();
      chk("lu_enter_valid", 32'(ex_valid), 32'd1);
      chk("lu_enter_rd", 32'(ex_rd_addr), 32'd7);

      // Load-use coinciding with flush.
      set_id(1, 0, 0, 0, 0, 5, 1, 1);
      cycle();
      set_id(1, 5, 32'd1, 2, 32'd2, 8, 1, 0);
      flush = 1;
      #1 chk("flush_stall", 32'(stall), 32'd0);
      cycle();
      chk("flush_valid", 32'(ex_valid), 32'd0);
      flush = 0;

      // Hold for three cycles with rd=9 in EX.
      set_id(1, 1, 32'h100, 2, 32'h200, 9, 1, 0);
      cycle();
      set_id(1, 3, 32'h300, 4, 32'h400, 10, 1, 0);
      ex_hold = 1;
      for (int i = 0; i < 3; i++) begin
         #1 chk("hold_stall", 32'(stall), 32'd1);
         chk("hold_rd", 32'(ex_rd_addr), 32'd9);
         chk("hold_src_a", src_a, 32'h100);
         cycle();
      end
      ex_hold = 0;
      cycle();
      chk("hold_release_rd", 32'(ex_rd_addr), 32'd10);
      chk("hold_release_src_a", src_a, 32'h300);

      // Asynchronous reset between edges with a live instruction.
      chk("pre_rst_valid", 32'(ex_valid), 32'd1);
      async_reset_pulse();
      cycle();
      chk("post_rst_reload", 32'(ex_rd_addr), 32'd10);

      for (int n = 0; n < 600; n++) begin
         randomize_inputs();
         if ($urandom_range(0, 39) == 0) async_reset_pulse();
         cycle();
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/id_ex_stage.md
ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, operand/result width.
REQ-002 SHALL have parameter SEL_WIDTH, default 4, ALU select width.
REQ-003 SHALL have parameter REG_ADDR_WIDTH, default 5, register address width.
REQ-004 i_clk  input  1  sole clock; all state updates on rising edge.
REQ-005 i_rst  input  1  reset; asynchronous and active-high.
REQ-006 i_id_valid  input  1  decode stage presents a valid instruction.
REQ-007 i_id_rs1_addr, i_id_rs2_addr, i_id_rd_addr  input  REG_ADDR_WIDTH each  source/destination register indices.
REQ-008 i_id_rs1_used, i_id_rs2_used  input  1 each  instruction reads rs1/rs2.
REQ-009 i_id_rs1_data, i_id_rs2_data, i_id_imm  input  DATA_WIDTH each  register file read data and sign-extended immediate.
REQ-010 i_id_alu_sel  input  SEL_WIDTH  ALU operation code.
REQ-011 i_id_use_imm, i_id_reg_write, i_id_mem_read  input  1 each  operand-B select, writes rd, is a load.
REQ-012 i_flush  input  1  branch/jump redirect; kill the instruction entering EX.
REQ-013 i_ex_hold  input  1  downstream stall; freeze EX contents.
REQ-014 i_mem_reg_write, i_mem_rd_addr, i_mem_data  input  1/REG_ADDR_WIDTH/DATA_WIDTH  EX/MEM result for forwarding.
REQ-015 i_wb_reg_write, i_wb_rd_addr, i_wb_data  input  1/REG_ADDR_WIDTH/DATA_WIDTH  MEM/WB result for forwarding.
REQ-016 o_stall  output  1  hold PC and IF/ID this cycle.
REQ-017 o_ex_valid  output  1  EX slot holds a live instruction.
REQ-018 o_src_a, o_src_b  output  DATA_WIDTH each  ALU operands; o_alu_sel  output  SEL_WIDTH  ALU select.
REQ-019 o_store_data  output  DATA_WIDTH  forwarded rs2 value for stores.
REQ-020 o_ex_rd_addr, o_ex_reg_write, o_ex_mem_read  output  REG_ADDR_WIDTH/1/1  destination and control carried forward.

Function
REQ-021 SHALL register all i_id_* fields into the EX slot on each rising edge when no hold/flush/bubble applies, o_ex_valid <= i_id_valid.
REQ-022 Load-use hazard SHALL be detected combinationally: o_ex_valid & o_ex_mem_read & o_ex_rd_addr!=0 & i_id_valid & ((rs1_used & rs1==ex_rd) | (rs2_used & rs2==ex_rd)).
REQ-023 On load-use hazard (no flush, no hold) SHALL insert a bubble: o_ex_valid<=0, o_ex_reg_write<=0, o_ex_mem_read<=0; o_stall=1 that cycle.
REQ-024 Update priority SHALL be: reset > i_flush > i_ex_hold > load-use bubble > normal load.
REQ-025 i_flush SHALL clear the EX slot (valid, reg_write, mem_read <= 0) next edge and force o_stall=0.
REQ-026 i_ex_hold (no flush) SHALL keep every EX register unchanged and assert o_stall=1.
REQ-027 o_stall SHALL equal !i_flush & (i_ex_hold | load_use).
REQ-028 Forwarding per operand (rs1, rs2) SHALL select: MEM data if i_mem_reg_write & i_mem_rd_addr!=0 & match; else WB data if i_wb_reg_write & i_wb_rd_addr!=0 & match; else registered register file data.
REQ-029 Address 0 SHALL never forward; x0 operand uses registered data.
REQ-030 o_src_a SHALL be forwarded rs1; o_src_b SHALL be registered imm when use_imm=1, else forwarded rs2; o_store_data SHALL always be forwarded rs2.
REQ-031 Forwarding muxes SHALL be combinational (zero latency from i_mem_*/i_wb_* to outputs); EX register latency is exactly one cycle.
REQ-032 When o_ex_valid=0, o_ex_reg_write and o_ex_mem_read SHALL read 0; data outputs are don't-care.

Reset
REQ-033 While i_rst=1, all EX registers SHALL clear to 0 immediately: o_ex_valid=0, o_ex_reg_write=0, o_ex_mem_read=0, o_alu_sel=0, o_ex_rd_addr=0, operand/imm registers=0.
REQ-034 Reset mid-hold or mid-bubble SHALL discard the held instruction; first edge after release loads ID normally.

Verification
REQ-035 ID: rs1=3 data 5, rs2=4 data 7, sel=0000, rd=6 -> next cycle o_src_a=5, o_src_b=7, o_alu_sel=0000, o_ex_valid=1.
REQ-036 EX rs1=3, i_mem_rd=3 data 0xAA, i_wb_rd=3 data 0xBB, both write -> o_src_a=0xAA; drop mem write -> 0xBB; rd=0 on both -> registered value.
REQ-037 EX load rd=5, ID valid rs2=5 rs2_used -> o_stall=1 one cycle, next cycle o_ex_valid=0, following cycle ID instruction enters.
REQ-038 Load-use and i_flush same cycle -> o_stall=0, next cycle o_ex_valid=0.
REQ-039 i_ex_hold high 3 cycles with EX rd=9 -> o_stall=1 each cycle, EX outputs constant, ID instruction loaded on first edge after hold drops.
REQ-040 i_rst pulsed asynchronously between edges while EX valid -> o_ex_valid and o_ex_reg_write go 0 without clock edge.
